aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
Sequencer for AES-128 key expansion. It loads a 128-bit cipher key and emits round keys 0..10 one at a time over a valid/ready stream. Each round it drives the round index to the external round-constant lookup and the rotated word to an external combinational SubWord S-box. It sits between the key input interface and the round-key consumer (cipher core or key RAM writer).

Parameters:
DWORD, 32, word width of key-schedule words and of the rcon/S-box buses
LENGTH, 128, key and round-key width (4 words)
ROUNDS, 10, index of the last round key emitted

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin expansion; sampled only in IDLE
clear  input  1  synchronous abort to IDLE; has priority over all transitions except rst
key_in  input  LENGTH  cipher key; w0 = key_in[127:96], w3 = key_in[31:0]
rnd  output  4  round index to the round-constant lookup (0 → 0x01000000 … 9 → 0x36000000)
rcon  input  DWORD  round constant returned for rnd (combinational, same cycle)
sub_in  output  DWORD  RotWord(w3) = {w3[23:0], w3[31:24]} to the S-box
sub_out  input  DWORD  SubWord(sub_in) from the S-box (combinational, same cycle)
busy  output  1  high in every state except IDLE
rk_valid  output  1  round key available
rk_ready  input  1  consumer accepts the round key
rk_data  output  LENGTH  round key {w0,w1,w2,w3}
rk_index  output  4  index of the round key on rk_data (0..ROUNDS)
done  output  1  one-cycle pulse after round key ROUNDS is accepted

Behaviour:
- States: IDLE, EMIT, CALC, DONE. Registers: w0..w3, idx (4 bits).
- Reset: async to IDLE. w0..w3=0, idx=0, busy=0, rk_valid=0, done=0, rk_data=0, rk_index=0, rnd=0, sub_in=0.
- IDLE: start=1 → load w0..w3 from key_in, idx=0, go to EMIT. start in any other state is ignored.
- EMIT: rk_valid=1, rk_data={w0,w1,w2,w3}, rk_index=idx.
  - rk_data and rk_index stay stable while rk_valid=1 and rk_ready=0.
  - A transfer occurs on a rising edge where rk_valid and rk_ready are both 1.
  - On transfer: idx==ROUNDS → DONE; otherwise → CALC.
- CALC: exactly one cycle, rk_valid=0. rnd=idx. Combinational update:
  - t = sub_out ^ rcon
  - n0 = w0 ^ t
  - n1 = w1 ^ n0
  - n2 = w2 ^ n1
  - n3 = w3 ^ n2
  - At the clock edge: w0..w3 ← n0..n3, idx ← idx+1, go to EMIT.
- DONE: done=1 for one cycle, busy=1, then IDLE. w0..w3 hold round key 10 until the next start.
- rnd and sub_in are driven from idx and w3 in every state. The rcon/sub_out inputs are consumed only in CALC.
- All XORs are width DWORD. No carries. idx never exceeds ROUNDS, and rnd never exceeds 9 when consumed.
- Latency, with rk_ready held high and start sampled at edge E0:
  - key 0 valid after E0
  - key k valid after edge E0+2k (key 10 after E0+20)
  - done high in the cycle after E0+21
- Back-pressure: each cycle rk_ready=0 in EMIT adds one cycle. There is no other stall source.
- clear=1 in any state → IDLE at the next edge. rk_valid=0, busy=0, no done pulse. w0..w3 and idx are left unchanged.
- start and clear together in IDLE: clear wins and the FSM stays in IDLE.
- rst asserted mid-expansion: immediate return to reset values. The next start restarts from round 0.

Test Plan:
- key_in=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 → rk_index 0 data = key; index 1 = a0fafe1788542cb123a339392a6c7605; index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done pulses one cycle later, exactly once.
- key_in=0, rk_ready=1 → index 1 = 62636363 repeated 4×; rnd observed in CALC cycles = 0,1,…,9 in order.
- Same FIPS key, rk_ready toggling 0/1 randomly → rk_data and rk_index stable while stalled; the 11 keys arrive in order with identical values; no key duplicated or dropped.
- clear asserted in CALC after index 3 is accepted → IDLE next cycle, busy=0, no done pulse. A new start then yields index 0 = new key_in.
- rst pulsed asynchronously mid-EMIT (between clock edges) → all outputs 0 immediately. start held high during EMIT is ignored, and a second start after done begins a fresh 11-key sequence.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key expansion sequencer.
// Holds the four schedule words, emits each round key on a valid/ready
// stream and derives the next key from an external S-box and rcon lookup.
module aes_key_sched_ctrl #(
  parameter int DWORD  = 32,
  parameter int LENGTH = 128,
  parameter int ROUNDS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic [LENGTH-1:0] key_in,
  output logic [3:0]        rnd,
  input  logic [DWORD-1:0]  rcon,
  output logic [DWORD-1:0]  sub_in,
  input  logic [DWORD-1:0]  sub_out,
  output logic              busy,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [LENGTH-1:0] rk_data,
  output logic [3:0]        rk_index,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, EMIT, CALC, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS);

  state_t           state_q, state_d;
  logic [DWORD-1:0] w0_q, w1_q, w2_q, w3_q;
  logic [DWORD-1:0] w0_d, w1_d, w2_d, w3_d;
  logic [3:0]       idx_q, idx_d;
  logic             rk_valid_q, rk_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DWORD-1:0] t, n0, n1, n2, n3;

  // RotWord: rotate the word left by one byte.
  function automatic logic [DWORD-1:0] rot_word(input logic [DWORD-1:0] w);
    return {w[DWORD-9:0], w[DWORD-1:DWORD-8]};
  endfunction

  assign rnd      = idx_q;
  assign sub_in   = rot_word(w3_q);
  assign rk_data  = {w0_q, w1_q, w2_q, w3_q};
  assign rk_index = idx_q;
  assign rk_valid = rk_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Next-state, next-key and registered-output computation.
  always_comb begin
    state_d = state_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    w3_d    = w3_q;
    idx_d   = idx_q;
    t       = sub_out ^ rcon;
    n0      = w0_q ^ t;
    n1      = w1_q ^ n0;
    n2      = w2_q ^ n1;
    n3      = w3_q ^ n2;
    case (state_q)
      IDLE: begin
        if (start) begin
          w0_d    = key_in[LENGTH-1 -: DWORD];
          w1_d    = key_in[LENGTH-1-DWORD -: DWORD];
          w2_d    = key_in[LENGTH-1-2*DWORD -: DWORD];
          w3_d    = key_in[DWORD-1:0];
          idx_d   = 4'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_valid_q && rk_ready) begin
          state_d = (idx_q == LAST_IDX) ? DONE : CALC;
        end
      end
      CALC: begin
        w0_d    = n0;
        w1_d    = n1;
        w2_d    = n2;
        w3_d    = n3;
        idx_d   = idx_q + 4'd1;
        state_d = EMIT;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort keeps the schedule words and index exactly as they were.
    if (clear) begin
      state_d = IDLE;
      w0_d    = w0_q;
      w1_d    = w1_q;
      w2_d    = w2_q;
      w3_d    = w3_q;
      idx_d   = idx_q;
    end
    rk_valid_d = (state_d == EMIT);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  // State, key words, index and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      w0_q       <= '0;
      w1_q       <= '0;
      w2_q       <= '0;
      w3_q       <= '0;
      idx_q      <= 4'd0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      w2_q       <= w2_d;
      w3_q       <= w3_d;
      idx_q      <= idx_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl with behavioural S-box and rcon.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         clear = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0]   rnd;
  logic [31:0]  rcon;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic         busy, rk_valid, done;
  logic         rk_ready = 1'b0;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;

  aes_key_sched_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .key_in(key_in),
    .rnd(rnd), .rcon(rcon), .sub_in(sub_in), .sub_out(sub_out),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_index(rk_index), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  // External combinational S-box and round-constant lookup.
  assign sub_out = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]], SBOX[sub_in[15:8]], SBOX[sub_in[7:0]]};
  always_comb begin
    case (rnd)
      4'd0: rcon = 32'h01000000;
      4'd1: rcon = 32'h02000000;
      4'd2: rcon = 32'h04000000;
      4'd3: rcon = 32'h08000000;
      4'd4: rcon = 32'h10000000;
      4'd5: rcon = 32'h20000000;
      4'd6: rcon = 32'h40000000;
      4'd7: rcon = 32'h80000000;
      4'd8: rcon = 32'h1b000000;
      4'd9: rcon = 32'h36000000;
      default: rcon = 32'h00000000;
    endcase
  end

  localparam logic [127:0] FIPS_RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] data;
    bit           chk;
  } exp_t;

  exp_t         sb_q[$];
  logic [3:0]   rnd_log[$];
  logic [127:0] exp_keys [11];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           done_cnt = 0;
  int           rdy_mode = 0;
  logic [3:0]   last_i = '0;
  logic [31:0]  last_w3 = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Queue the expected keys 0..cnt-1; data is checked for indices below nchk.
  task automatic push_exp(input int cnt, input int nchk);
    for (int i = 0; i < cnt; i++) begin
      exp_t e;
      e.idx  = 4'(i);
      e.data = exp_keys[i];
      e.chk  = (i < nchk);
      sb_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [127:0] k, input int hold);
    @(negedge clk);
    key_in = k;
    start  = 1'b1;
    repeat (hold) @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      if (done) break;
      cyc++;
    end
    if (cyc >= 400) chk("done_timeout", 128'd0, 128'd1);
  endtask

  // Ready driver: 0 = always ready, 1 = random, 2 = never ready.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: rk_ready = 1'b1;
        1: rk_ready = 1'(($urandom % 2));
        default: rk_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pops, stall stability, CALC bus values, done pulse.
  logic         hold_v = 1'b0;
  logic [127:0] hold_d;
  logic [3:0]   hold_i;
  logic         pend_done = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      hold_v    = 1'b0;
      pend_done = 1'b0;
    end else begin
      if (done || pend_done) chk("done_pulse", 128'(done), 128'(pend_done));
      if (done) done_cnt++;
      pend_done = 1'b0;
      if (rk_valid) begin
        if (hold_v) begin
          chk("stall_data", rk_data, hold_d);
          chk("stall_index", 128'(rk_index), 128'(hold_i));
        end
        if (rk_ready) begin
          hold_v = 1'b0;
          if (sb_q.size() == 0) begin
            chk("unexpected_key", 128'(rk_index), 128'hf);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("rk_index", 128'(rk_index), 128'(e.idx));
            if (e.chk) chk("rk_data", rk_data, e.data);
          end
          last_i    = rk_index;
          last_w3   = rk_data[31:0];
          pend_done = (rk_index == 4'd10);
        end else begin
          hold_v = 1'b1;
          hold_d = rk_data;
          hold_i = rk_index;
        end
      end else begin
        hold_v = 1'b0;
      end
      if (busy && !rk_valid && !done) begin
        chk("calc_rnd", 128'(rnd), 128'(last_i));
        chk("calc_sub_in", 128'(sub_in), 128'({last_w3[23:0], last_w3[31:24]}));
        rnd_log.push_back(rnd);
      end
    end
  end

  initial begin
    int cyc;
    int d0;
    bit found;
    // Reset state.
    #1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_valid", 128'(rk_valid), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_data", rk_data, 128'd0);
    chk("rst_index", 128'(rk_index), 128'd0);
    chk("rst_rnd", 128'(rnd), 128'd0);
    chk("rst_sub_in", 128'(sub_in), 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // FIPS key, always ready, latency to done.
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    exp_keys = FIPS_RK;
    push_exp(11, 11);
    d0 = done_cnt;
    pulse_start(FIPS_RK[0], 1);
    wait_done(cyc);
    chk("done_latency", 128'(cyc), 128'd21);
    repeat (3) @(negedge clk);
    chk("done_once", 128'(done_cnt - d0), 128'd1);
    chk("idle_busy", 128'(busy), 128'd0);
    chk("sb_empty1", 128'(sb_q.size()), 128'd0);

    // Zero key: round key 1/2 and rnd order.
    for (int i = 0; i < 11; i++) exp_keys[i] = '0;
    exp_keys[1] = {4{32'h62636363}};
    exp_keys[2] = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    push_exp(11, 3);
    rnd_log.delete();
    pulse_start(128'd0, 1);
    wait_done(cyc);
    repeat (2) @(negedge clk);
    chk("rnd_log_len", 128'(rnd_log.size()), 128'd10);
    for (int i = 0; i < 10 && i < rnd_log.size(); i++) chk("rnd_order", 128'(rnd_log[i]), 128'(i));
    chk("sb_empty2", 128'(sb_q.size()), 128'd0);

    // Random back-pressure, start held high into EMIT.
    rdy_mode = 1;
    exp_keys = FIPS_RK;
    push_exp(11, 11);
    d0 = done_cnt;
    pulse_start(FIPS_RK[0], 6);
    wait_done(cyc);
    repeat (3) @(negedge clk);
    chk("done_once_bp", 128'(done_cnt - d0), 128'd1);
    chk("sb_empty3", 128'(sb_q.size()), 128'd0);
    rdy_mode = 0;

    // clear in CALC after index 3.
    push_exp(4, 4);
    d0 = done_cnt;
    pulse_start(FIPS_RK[0], 1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (busy && !rk_valid && !done && rnd == 4'd3) found = 1'b1;
    end
    chk("clear_reach_calc", 128'(found), 128'd1);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    chk("clear_busy", 128'(busy), 128'd0);
    chk("clear_valid", 128'(rk_valid), 128'd0);
    repeat (5) @(negedge clk);
    chk("clear_no_done", 128'(done_cnt - d0), 128'd0);
    chk("sb_empty4", 128'(sb_q.size()), 128'd0);

    // start together with clear in IDLE stays idle.
    @(negedge clk);
    start = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    clear = 1'b0;
    chk("start_clear_busy", 128'(busy), 128'd0);
    chk("start_clear_valid", 128'(rk_valid), 128'd0);

    // New key after clear.
    exp_keys[0] = 128'h000102030405060708090a0b0c0d0e0f;
    exp_keys[1] = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    push_exp(11, 2);
    pulse_start(128'h000102030405060708090a0b0c0d0e0f, 1);
    wait_done(cyc);
    repeat (2) @(negedge clk);
    chk("sb_empty5", 128'(sb_q.size()), 128'd0);

    // Asynchronous reset while stalled in EMIT.
    rdy_mode = 2;
    pulse_start(FIPS_RK[0], 1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_valid", 128'(rk_valid), 128'd0);
    chk("arst_data", rk_data, 128'd0);
    chk("arst_index", 128'(rk_index), 128'd0);
    chk("arst_sub_in", 128'(sub_in), 128'd0);
    chk("arst_done", 128'(done), 128'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    rdy_mode = 0;

    // Two back-to-back full runs after reset.
    exp_keys = FIPS_RK;
    for (int r = 0; r < 2; r++) begin
      push_exp(11, 11);
      d0 = done_cnt;
      pulse_start(FIPS_RK[0], 1);
      wait_done(cyc);
      repeat (2) @(negedge clk);
      chk("rerun_done", 128'(done_cnt - d0), 128'd1);
    end
    chk("sb_empty6", 128'(sb_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
